// File: rtl/register_file_if.sv
// Decode/commit bus between issue, ROB and the architectural register file.
// Latency: n/a (signal bundle only); read results are combinational from the slave.
// Backpressure: none on this bus; rdy/stall gate updates inside the register file.
interface register_file_if #(
  parameter int XLEN           = 32,
  parameter int ROB_SIZE_WIDTH = 4,
  parameter int DEP_WIDTH      = ROB_SIZE_WIDTH + 1
);
  logic                      rdy;
  logic                      flush;
  logic                      stall;
  logic                      dec_ready;
  logic                      dec_writes_rd;
  logic [4:0]                dec_rd;
  logic [4:0]                dec_rs1;
  logic [4:0]                dec_rs2;
  logic [ROB_SIZE_WIDTH-1:0] rob_tail_id;
  logic                      rob_rf_enable;
  logic [4:0]                rob_rf_rd;
  logic [XLEN-1:0]           rob_rf_val;
  logic [ROB_SIZE_WIDTH-1:0] rob_rf_id;
  logic [XLEN-1:0]           rf_val1;
  logic [XLEN-1:0]           rf_val2;
  logic [DEP_WIDTH-1:0]      rf_dep1;
  logic [DEP_WIDTH-1:0]      rf_dep2;

  // Decoder/ROB side drives requests and consumes read results.
  modport master (
    output rdy, flush, stall, dec_ready, dec_writes_rd, dec_rd, dec_rs1, dec_rs2,
           rob_tail_id, rob_rf_enable, rob_rf_rd, rob_rf_val, rob_rf_id,
    input  rf_val1, rf_val2, rf_dep1, rf_dep2
  );

  // Register file side.
  modport slave (
    input  rdy, flush, stall, dec_ready, dec_writes_rd, dec_rd, dec_rs1, dec_rs2,
           rob_tail_id, rob_rf_enable, rob_rf_rd, rob_rf_val, rob_rf_id,
    output rf_val1, rf_val2, rf_dep1, rf_dep2
  );
endinterface

// File: rtl/register_file.sv
// Architectural register file with per-register ROB producer tags (rename map).
// Latency: reads are combinational (0 cycles); commit/rename/flush land at the next clk edge.
// Backpressure: all state frozen while rdy is low; stall suppresses rename. Option: RF_COMMIT_BYPASS_EN.
module register_file #(
  parameter int XLEN           = 32,
  parameter int ROB_SIZE_WIDTH = 4,
  parameter int DEP_WIDTH      = ROB_SIZE_WIDTH + 1
) (
  input logic           clk,
  input logic           rst,
  register_file_if.slave bus
);

  // All-ones tag marks "value is architectural, no pending producer".
  localparam logic [DEP_WIDTH-1:0] NONE = '1;

  logic [XLEN-1:0]      r_val [32];
  logic [DEP_WIDTH-1:0] r_dep [32];

  logic                 w_commit;
  logic                 w_rename;
  logic [DEP_WIDTH-1:0] w_commit_tag;
  logic [DEP_WIDTH-1:0] w_rename_tag;

  // ROB ids are zero-extended so a real producer tag can never alias NONE.
  assign w_commit_tag = DEP_WIDTH'(bus.rob_rf_id);
  assign w_rename_tag = DEP_WIDTH'(bus.rob_tail_id);
  assign w_commit     = bus.rdy && bus.rob_rf_enable && (bus.rob_rf_rd != 5'd0);
  assign w_rename     = bus.rdy && !bus.flush && !bus.stall && bus.dec_ready &&
                        bus.dec_writes_rd && (bus.dec_rd != 5'd0);

  // State update: value write on commit, tag clear/rename, flush wipes all tags.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        r_val[i] <= '0;
        r_dep[i] <= NONE;
      end
    end else if (bus.rdy) begin
      // The committing value is always written, even in a flush cycle (JALR).
      if (w_commit) begin
        r_val[bus.rob_rf_rd] <= bus.rob_rf_val;
      end
      if (bus.flush) begin
        for (int i = 0; i < 32; i++) begin
          r_dep[i] <= NONE;
        end
      end else begin
        // Only clear the tag if no younger producer has since renamed it.
        if (w_commit && (r_dep[bus.rob_rf_rd] == w_commit_tag)) begin
          r_dep[bus.rob_rf_rd] <= NONE;
        end
        // Rename is written last so it wins over a same-register commit clear.
        if (w_rename) begin
          r_dep[bus.dec_rd] <= w_rename_tag;
        end
      end
    end
  end

`ifdef RF_COMMIT_BYPASS_EN
  // Source port 1: stored state, overridden by a same-cycle commit to the same register.
  always_comb begin
    bus.rf_val1 = r_val[bus.dec_rs1];
    bus.rf_dep1 = r_dep[bus.dec_rs1];
    if (bus.dec_rs1 == 5'd0) begin
      bus.rf_val1 = '0;
      bus.rf_dep1 = NONE;
    end else if (bus.rob_rf_enable && (bus.rob_rf_rd == bus.dec_rs1)) begin
      bus.rf_val1 = bus.rob_rf_val;
      if (r_dep[bus.dec_rs1] == w_commit_tag) begin
        bus.rf_dep1 = NONE;
      end
    end
  end

  // Source port 2: same forwarding as port 1.
  always_comb begin
    bus.rf_val2 = r_val[bus.dec_rs2];
    bus.rf_dep2 = r_dep[bus.dec_rs2];
    if (bus.dec_rs2 == 5'd0) begin
      bus.rf_val2 = '0;
      bus.rf_dep2 = NONE;
    end else if (bus.rob_rf_enable && (bus.rob_rf_rd == bus.dec_rs2)) begin
      bus.rf_val2 = bus.rob_rf_val;
      if (r_dep[bus.dec_rs2] == w_commit_tag) begin
        bus.rf_dep2 = NONE;
      end
    end
  end
`else
  // Source port 1: stored state only; a commit shows up the following cycle.
  always_comb begin
    bus.rf_val1 = r_val[bus.dec_rs1];
    bus.rf_dep1 = r_dep[bus.dec_rs1];
    if (bus.dec_rs1 == 5'd0) begin
      bus.rf_val1 = '0;
      bus.rf_dep1 = NONE;
    end
  end

  // Source port 2: stored state only.
  always_comb begin
    bus.rf_val2 = r_val[bus.dec_rs2];
    bus.rf_dep2 = r_dep[bus.dec_rs2];
    if (bus.dec_rs2 == 5'd0) begin
      bus.rf_val2 = '0;
      bus.rf_dep2 = NONE;
    end
  end
`endif

endmodule

// File: tb/tb_register_file.sv
// Directed-vector bench for register_file: rename, commit, priority, flush, freeze, reset.
// Latency: checks combinational reads #1 after input changes and state #1 after each edge.
// Backpressure: exercises rdy-low freeze and stall-suppressed rename.
module tb_register_file;

  localparam int XLEN = 32;
  localparam int RSW  = 4;
  localparam int DW   = RSW + 1;
  localparam logic [31:0] NONE = 32'h1F;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  register_file_if #(.XLEN(XLEN), .ROB_SIZE_WIDTH(RSW), .DEP_WIDTH(DW)) bus ();

  register_file #(.XLEN(XLEN), .ROB_SIZE_WIDTH(RSW), .DEP_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rdy           = 1'b1;
    bus.flush         = 1'b0;
    bus.stall         = 1'b0;
    bus.dec_ready     = 1'b0;
    bus.dec_writes_rd = 1'b0;
    bus.dec_rd        = 5'd0;
    bus.rob_tail_id   = '0;
    bus.rob_rf_enable = 1'b0;
    bus.rob_rf_rd     = 5'd0;
    bus.rob_rf_val    = '0;
    bus.rob_rf_id     = '0;
  endtask

  task automatic rename(input logic [4:0] rd, input logic [3:0] tail);
    bus.dec_ready     = 1'b1;
    bus.dec_writes_rd = 1'b1;
    bus.dec_rd        = rd;
    bus.rob_tail_id   = tail;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [3:0] id, input logic [31:0] val);
    bus.rob_rf_enable = 1'b1;
    bus.rob_rf_rd     = rd;
    bus.rob_rf_id     = id;
    bus.rob_rf_val    = val;
  endtask

  // Reads register r on port 1 and compares value and tag.
  task automatic rd1(input string tag, input logic [4:0] r, input logic [31:0] ev, input logic [31:0] ed);
    bus.dec_rs1 = r;
    #1;
    chk({tag, "_val"}, bus.rf_val1, ev);
    chk({tag, "_dep"}, 32'(bus.rf_dep1), ed);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    idle();
    bus.dec_rs1 = 5'd0;
    bus.dec_rs2 = 5'd0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state on both ports for every index.
    for (int i = 0; i < 32; i++) begin
      bus.dec_rs1 = 5'(i);
      bus.dec_rs2 = 5'(31 - i);
      #1;
      chk("rst_val1", bus.rf_val1, 32'h0);
      chk("rst_dep1", 32'(bus.rf_dep1), NONE);
      chk("rst_val2", bus.rf_val2, 32'h0);
      chk("rst_dep2", 32'(bus.rf_dep2), NONE);
    end

    // Rename x5 tail 3: same-cycle read still sees the old (empty) tag.
    rename(5'd5, 4'd3);
    rd1("ren_same", 5'd5, 32'h0, NONE);
    tick();
    idle();
    rd1("ren_x5", 5'd5, 32'h0, 32'h03);
    commit(5'd5, 4'd3, 32'hDEADBEEF);
    tick();
    idle();
    rd1("cmt_x5", 5'd5, 32'hDEADBEEF, NONE);

    // Younger producer keeps the tag when the older one commits.
    rename(5'd7, 4'd2);
    tick();
    rename(5'd7, 4'd6);
    tick();
    idle();
    commit(5'd7, 4'd2, 32'h11);
    tick();
    idle();
    rd1("young_x7", 5'd7, 32'h11, 32'h06);

    // Same-cycle commit and rename of x9: rename wins, value still written.
    rename(5'd9, 4'd4);
    tick();
    idle();
    commit(5'd9, 4'd4, 32'h22);
    rename(5'd9, 4'd8);
    tick();
    idle();
    rd1("prio_x9", 5'd9, 32'h22, 32'h08);

    // Flush with coincident commit; a rename in the flush cycle is dropped.
    rename(5'd1, 4'd1);
    tick();
    rename(5'd2, 4'd2);
    tick();
    rename(5'd3, 4'd3);
    tick();
    idle();
    rd1("pre_fl_x2", 5'd2, 32'h0, 32'h02);
    bus.flush = 1'b1;
    commit(5'd1, 4'd1, 32'h40);
    rename(5'd10, 4'd5);
    tick();
    idle();
    rd1("fl_x1", 5'd1, 32'h40, NONE);
    rd1("fl_x2", 5'd2, 32'h0, NONE);
    rd1("fl_x3", 5'd3, 32'h0, NONE);
    rd1("fl_x10", 5'd10, 32'h0, NONE);
    rd1("fl_x9", 5'd9, 32'h22, NONE);

    // Stall suppresses rename.
    bus.stall = 1'b1;
    rename(5'd11, 4'd5);
    tick();
    idle();
    rd1("stall_x11", 5'd11, 32'h0, NONE);

    // rdy low freezes everything.
    bus.rdy = 1'b0;
    commit(5'd5, 4'd3, 32'h99);
    rename(5'd5, 4'd7);
    tick();
    idle();
    rd1("frz_x5", 5'd5, 32'hDEADBEEF, NONE);

    // Writes to x0 are ignored.
    commit(5'd0, 4'd0, 32'h77);
    rename(5'd0, 4'd2);
    tick();
    idle();
    rd1("x0", 5'd0, 32'h0, NONE);

    // Commit visibility in the commit cycle, with and without bypass.
    rename(5'd4, 4'd1);
    tick();
    idle();
    bus.dec_rs2 = 5'd4;
    commit(5'd4, 4'd1, 32'h55);
    #1;
`ifdef RF_COMMIT_BYPASS_EN
    chk("byp_val2", bus.rf_val2, 32'h55);
    chk("byp_dep2", 32'(bus.rf_dep2), NONE);
`else
    chk("nobyp_val2", bus.rf_val2, 32'h0);
    chk("nobyp_dep2", 32'(bus.rf_dep2), 32'h01);
`endif
    tick();
    idle();
    #1;
    chk("post_val2", bus.rf_val2, 32'h55);
    chk("post_dep2", 32'(bus.rf_dep2), NONE);

    // Reset wins over rdy low and an active commit.
    rename(5'd6, 4'd2);
    tick();
    idle();
    bus.rdy = 1'b0;
    commit(5'd5, 4'd3, 32'h123);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    rd1("rst2_x5", 5'd5, 32'h0, NONE);
    rd1("rst2_x6", 5'd6, 32'h0, NONE);
    rd1("rst2_x4", 5'd4, 32'h0, NONE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width.
REQ-002 SHALL have parameter ROB_SIZE_WIDTH, default 4, ROB index width.
REQ-003 SHALL have parameter DEP_WIDTH, default ROB_SIZE_WIDTH+1, dependency tag width; all-ones = no dependency (NONE).
REQ-004 SHALL have port clk  input  1  clock.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have ports rdy, flush, stall  input  1 each  global ready, pipeline flush from ROB, decode stall.
REQ-007 SHALL have ports dec_ready, dec_writes_rd  input  1 each  decoder issue valid; issued instruction writes rd.
REQ-008 SHALL have ports dec_rd, dec_rs1, dec_rs2  input  5 each  destination and source register indices.
REQ-009 SHALL have port rob_tail_id  input  ROB_SIZE_WIDTH  ROB slot allocated to the issuing instruction.
REQ-010 SHALL have ports rob_rf_enable / rob_rf_rd / rob_rf_val / rob_rf_id  input  1 / 5 / XLEN / ROB_SIZE_WIDTH  commit write: valid, register, value, ROB slot of committed instruction.
REQ-011 SHALL have ports rf_val1, rf_val2  output  XLEN each  values of dec_rs1, dec_rs2.
REQ-012 SHALL have ports rf_dep1, rf_dep2  output  DEP_WIDTH each  pending-producer tags of dec_rs1, dec_rs2.

Function
REQ-013 SHALL hold 32 value registers and 32 dependency tags; x0 value always reads 0, x0 tag always reads NONE, and writes to x0 are ignored.
REQ-014 SHALL drive rf_val*/rf_dep* combinationally from dec_rs1/dec_rs2 (zero-cycle read latency).
REQ-015 SHALL, on commit (rdy && rob_rf_enable && rob_rf_rd != 0), write rob_rf_val into value[rob_rf_rd] at the next clk edge.
REQ-016 SHALL, on commit, set tag[rob_rf_rd] to NONE only if tag[rob_rf_rd] == {1'b0, rob_rf_id}; otherwise the tag is unchanged (a younger producer exists).
REQ-017 SHALL, on rename (rdy && !flush && !stall && dec_ready && dec_writes_rd && dec_rd != 0), set tag[dec_rd] to {1'b0, rob_tail_id} at the next edge.
REQ-018 SHALL give rename priority over commit-clear when both target the same register in one cycle; the value write still occurs.
REQ-019 SHALL, on flush (rdy && flush), set all 32 tags to NONE, suppress rename, and still perform a same-cycle commit value write (JALR commit coincides with flush).
REQ-020 SHALL report source tags from state before the same-cycle rename; an instruction with rs == rd sees the old producer, not itself.
REQ-021 SHALL freeze all state while rdy is low.
REQ-022 SHALL never produce a tag with MSB set other than NONE.

Reset
REQ-023 SHALL, when rst is high at a clk edge, clear all values to 0 and all tags to NONE, regardless of rdy, flush, or commit.
REQ-024 SHALL hold no other state; outputs after reset: rf_val* = 0, rf_dep* = NONE for every index.

Configuration
REQ-025 SHALL, with RF_COMMIT_BYPASS_EN defined, forward a same-cycle commit to reads: if rob_rf_enable && rob_rf_rd == dec_rsN != 0, rf_valN = rob_rf_val; rf_depN = NONE when the stored tag equals {1'b0, rob_rf_id}, else the stored tag.
REQ-026 SHALL, without RF_COMMIT_BYPASS_EN, return stored state only; the same-cycle commit becomes visible the following cycle.

Verification
REQ-027 Reset, then read all 32 indices -> rf_val = 0, rf_dep = 5'b11111.
REQ-028 Rename x5 with tail=3; next cycle dec_rs1=5 -> rf_dep1 = 5'b00011; commit x5 id=3 val=0xDEADBEEF -> next cycle rf_dep1 = NONE, rf_val1 = 0xDEADBEEF.
REQ-029 Rename x7 tail=2, then rename x7 tail=6, then commit x7 id=2 val=0x11 -> rf_dep = 5'b00110, rf_val = 0x11.
REQ-030 Same cycle: commit x9 id=4 val=0x22 and rename x9 tail=8 -> rf_dep = 5'b01000, rf_val = 0x22.
REQ-031 Rename x1/x2/x3, then flush with commit x1 val=0x40 -> all tags NONE, value[x1] = 0x40; a rename in the flush cycle is dropped.
REQ-032 RF_COMMIT_BYPASS_EN defined: commit x4 id=1 val=0x55 while dec_rs2=4 and tag=5'b00001 -> same cycle rf_val2 = 0x55, rf_dep2 = NONE; undefined -> rf_val2 = old value, rf_dep2 = 5'b00001.
